// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM encodings, error codes and the default frame start byte.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

  // Payload checksum is a plain modulo-256 byte sum.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs accepted bytes little-endian into a word and pulses word_ready
// the cycle after the last lane is filled.
module word_assembler
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_ready,
  output logic                  last_lane
);

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] LAST = LANE_W'(LANES - 1);

  logic [LANE_W-1:0]     lane_r;
  logic [DATA_WIDTH-1:0] word_r;
  logic                  word_ready_r;

  assign last_lane  = (lane_r == LAST);
  assign word       = word_r;
  assign word_ready = word_ready_r;

  // Byte lane pointer, restarted at the beginning of every payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_r <= '0;
    end else if (clear) begin
      lane_r <= '0;
    end else if (push) begin
      lane_r <= last_lane ? '0 : lane_r + LANE_W'(1);
    end else begin
      lane_r <= lane_r;
    end
  end

  // Insert the accepted byte into its lane; every lane is rewritten per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_r <= '0;
    end else if (push) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_r == LANE_W'(i)) begin
          word_r[8*i +: 8] <= byte_in;
        end
      end
    end else begin
      word_r <= word_r;
    end
  end

  // One-cycle strobe, aligned with the completed word in word_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_ready_r <= 1'b0;
    end else if (clear) begin
      word_ready_r <= 1'b0;
    end else begin
      word_ready_r <= push && last_lane;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes words into the instruction
// BRAM, verifies the checksum and keeps the core stalled until success.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          DATA_WIDTH     = 32,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          MAX_WORDS      = 1024,
  parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] i_w_addr,
  output logic [DATA_WIDTH-1:0] i_w_dat,
  output logic                  i_w_enb,
  output logic                  cpu_stall,
  output logic                  load_done,
  output logic                  load_err,
  output logic [1:0]            err_code
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  state_t                state_r;
  logic [7:0]            len_lo_r;
  logic [15:0]           len_r;
  logic [15:0]           word_cnt_r;
  logic [7:0]            sum_r;
  logic [TO_W-1:0]       to_cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  done_r;
  logic                  err_r;
  logic [1:0]            err_code_r;
  logic                  stall_r;

  logic                  fire_s;
  logic                  in_frame_s;
  logic                  restart_s;
  logic                  timeout_s;
  logic                  asm_clear_s;
  logic                  asm_push_s;
  logic [15:0]           len_next_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic                  word_ready_s;
  logic                  last_lane_s;

  // Frame control decode shared by the FSM, counters and assembler.
  always_comb begin
    fire_s      = byte_valid;
    len_next_s  = {byte_in, len_lo_r};
    in_frame_s  = 1'b0;
    restart_s   = 1'b0;
    case (state_r)
      ST_LEN_LO, ST_LEN_HI, ST_PAYLOAD, ST_CHECK: in_frame_s = 1'b1;
      ST_IDLE, ST_DONE, ST_ERROR:                 restart_s  = byte_valid && (byte_in == MAGIC);
      default:                                    in_frame_s = 1'b0;
    endcase
    timeout_s   = in_frame_s && !fire_s && (to_cnt_r == TO_MAX);
    asm_clear_s = (state_r == ST_LEN_HI) && fire_s;
    asm_push_s  = (state_r == ST_PAYLOAD) && fire_s;
  end

  word_assembler #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear_s),
    .push       (asm_push_s),
    .byte_in    (byte_in),
    .word       (word_s),
    .word_ready (word_ready_s),
    .last_lane  (last_lane_s)
  );

  // Frame FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      len_lo_r   <= 8'd0;
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      sum_r      <= 8'd0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      stall_r    <= 1'b1;
    end else if (restart_s) begin
      state_r    <= ST_LEN_LO;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= ERR_NONE;
      stall_r    <= 1'b1;
    end else if (timeout_s) begin
      state_r    <= ST_ERROR;
      err_r      <= 1'b1;
      err_code_r <= ERR_TIMEOUT;
      stall_r    <= 1'b1;
    end else if (fire_s) begin
      case (state_r)
        ST_LEN_LO: begin
          len_lo_r <= byte_in;
          state_r  <= ST_LEN_HI;
        end
        ST_LEN_HI: begin
          len_r      <= len_next_s;
          word_cnt_r <= 16'd0;
          sum_r      <= 8'd0;
          if (32'(len_next_s) > 32'(MAX_WORDS)) begin
            state_r    <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= ERR_LEN;
          end else if (len_next_s == 16'd0) begin
            state_r <= ST_CHECK;
          end else begin
            state_r <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          sum_r <= csum_add(sum_r, byte_in);
          if (last_lane_s) begin
            word_cnt_r <= word_cnt_r + 16'd1;
            if (word_cnt_r == len_r - 16'd1) begin
              state_r <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (byte_in == sum_r) begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            stall_r <= 1'b0;
          end else begin
            state_r    <= ST_ERROR;
            err_r      <= 1'b1;
            err_code_r <= ERR_CSUM;
            stall_r    <= 1'b1;
          end
        end
        default: state_r <= state_r;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Inter-byte idle counter, only live while a frame is open.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= '0;
    end else if (!in_frame_s || fire_s) begin
      to_cnt_r <= '0;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end

  // Write address: zeroed at payload start, stepped after each word write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= '0;
    end else if (asm_clear_s) begin
      addr_r <= '0;
    end else if (word_ready_s) begin
      addr_r <= addr_r + ADDR_WIDTH'(32'd4);
    end else begin
      addr_r <= addr_r;
    end
  end

  assign byte_ready = 1'b1;
  assign i_w_addr   = addr_r;
  assign i_w_dat    = word_s;
  assign i_w_enb    = word_ready_s;
  assign cpu_stall  = stall_r;
  assign load_done  = done_r;
  assign load_err   = err_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected BRAM writes are queued as
// bytes are driven and popped when the write strobe appears.
module tb_imem_loader;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] i_w_addr;
  logic [31:0] i_w_dat;
  logic        i_w_enb;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [1:0]  err_code;

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [63:0] exp_q[$];
  bit          wr_due = 1'b0;
  logic [63:0] mon_e;
  logic [31:0] img[0:3];

  always #5 clk = ~clk;

  imem_loader #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_WORDS(1024),
    .MAGIC(8'hA5), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .i_w_addr(i_w_addr), .i_w_dat(i_w_dat),
    .i_w_enb(i_w_enb), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_err(load_err), .err_code(err_code)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write monitor: strobe must coincide with the bench's expectation.
  always @(negedge clk) begin
    if (!rst && (i_w_enb || wr_due)) begin
      check_eq("w_enb", 64'(i_w_enb), 64'(wr_due));
      if (i_w_enb) begin
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("w_addr", 64'(i_w_addr), 64'(mon_e[63:32]));
          check_eq("w_dat", 64'(i_w_dat), 64'(mon_e[31:0]));
        end else begin
          check_eq("w_extra", 64'(i_w_enb), 64'd0);
        end
      end
    end
    wr_due = 1'b0;
  end

  task automatic send_byte(input logic [7:0] b, input bit wr, input logic [63:0] e);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    if (wr) begin
      exp_q.push_back(e);
      wr_due = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] len, input logic [7:0] adj, input bit gap);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    send_byte(8'hA5, 1'b0, 64'd0);
    send_byte(len[7:0], 1'b0, 64'd0);
    send_byte(len[15:8], 1'b0, 64'd0);
    for (int i = 0; i < int'(len); i++) begin
      for (int j = 0; j < 4; j++) begin
        b = img[i][8*j +: 8];
        s = s + b;
        send_byte(b, j == 3, {32'(4 * i), img[i]});
        if (gap) idle(1);
      end
    end
    send_byte(s + adj, 1'b0, 64'd0);
    idle(2);
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic [1:0] code, input logic stall);
    check_eq({tag, "_done"}, 64'(load_done), 64'(done));
    check_eq({tag, "_err"}, 64'(load_err), 64'(err));
    check_eq({tag, "_code"}, 64'(err_code), 64'(code));
    check_eq({tag, "_stall"}, 64'(cpu_stall), 64'(stall));
    check_eq({tag, "_qlen"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, 64'(byte_ready), 64'd1);
    check_eq({tag, "_enb"}, 64'(i_w_enb), 64'd0);
    check_eq({tag, "_addr"}, 64'(i_w_addr), 64'd0);
    check_eq({tag, "_dat"}, 64'(i_w_dat), 64'd0);
    check_eq({tag, "_done"}, 64'(load_done), 64'd0);
    check_eq({tag, "_err"}, 64'(load_err), 64'd0);
    check_eq({tag, "_code"}, 64'(err_code), 64'd0);
    check_eq({tag, "_stall"}, 64'(cpu_stall), 64'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;

    // Two-word frame with a valid checksum, one idle cycle between bytes.
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    send_frame(16'd2, 8'd0, 1'b1);
    check_status("ok", 1'b1, 1'b0, 2'b00, 1'b0);

    // Same frame with a bad checksum: writes still happen.
    send_frame(16'd2, 8'd1, 1'b0);
    check_status("csum", 1'b0, 1'b1, 2'b10, 1'b1);

    // Leading junk dropped, then an oversized length.
    send_byte(8'h00, 1'b0, 64'd0);
    send_byte(8'hFF, 1'b0, 64'd0);
    send_byte(8'hA5, 1'b0, 64'd0);
    send_byte(8'h03, 1'b0, 64'd0);
    send_byte(8'h04, 1'b0, 64'd0);
    idle(3);
    check_status("len", 1'b0, 1'b1, 2'b01, 1'b1);

    // Stall mid-payload until the idle timeout fires.
    send_byte(8'hA5, 1'b0, 64'd0);
    send_byte(8'h01, 1'b0, 64'd0);
    send_byte(8'h00, 1'b0, 64'd0);
    send_byte(8'h13, 1'b0, 64'd0);
    idle(10);
    check_status("to_early", 1'b0, 1'b0, 2'b00, 1'b1);
    idle(30);
    check_status("to", 1'b0, 1'b1, 2'b11, 1'b1);

    // Zero-length frame recovers from the error.
    send_byte(8'hA5, 1'b0, 64'd0);
    send_byte(8'h00, 1'b0, 64'd0);
    send_byte(8'h00, 1'b0, 64'd0);
    send_byte(8'h00, 1'b0, 64'd0);
    idle(2);
    check_status("empty", 1'b1, 1'b0, 2'b00, 1'b0);

    // Four words with byte_valid held high the whole frame.
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h0123_4567;
    img[2] = 32'hA5A5_A5A5;
    img[3] = 32'h89AB_CDEF;
    send_frame(16'd4, 8'd0, 1'b0);
    check_status("b2b", 1'b1, 1'b0, 2'b00, 1'b0);

    // Asynchronous reset in the middle of the next frame.
    send_byte(8'hA5, 1'b0, 64'd0);
    send_byte(8'h04, 1'b0, 64'd0);
    send_byte(8'h00, 1'b0, 64'd0);
    send_byte(8'h11, 1'b0, 64'd0);
    send_byte(8'h22, 1'b0, 64'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset("arst");
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    check_status("post_rst", 1'b0, 1'b0, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
